multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the 9-bit Program1 processor; sequences each instruction through fetch, decode, execute, memory and writeback.
- Owns the PC and the instruction register (IR). Drives ALU-op and register-write strobes to the datapath.
- Runs a valid/ready request handshake to data memory, which has variable latency.
- Starts on a `start` pulse and raises `done` when the PC reaches PROG_LEN.

---
 rtl/prog_pkg.sv | 35 +++
 rtl/pc_next.sv | 25 ++
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the Program1 multi-cycle sequencer: opcode and
// state encodings, opcode field position and the branch offset extender.
package prog_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_LDR = 3'b100,
        OP_STR = 3'b101,
        OP_BR  = 3'b110,
        OP_BRZ = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // Branch offset lives in ir[5:0]; callers truncate to their PC width,
    // which gives modulo-2^PC_W branch arithmetic for free.
    function automatic logic [31:0] sext_off(input logic [8:0] ir);
        return {{26{ir[5]}}, ir[5:0]};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: taken branch target or sequential increment.
module pc_next
    import prog_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic [8:0]      ir,
    input  logic            zero_flag,
    input  logic            branch_sel,
    output logic [PC_W-1:0] next_pc
);

    opcode_e opcode;
    logic    take;

    assign opcode = opcode_e'(ir[OPC_MSB:OPC_LSB]);

    // branch_sel qualifies the decision to the cycle in which branches resolve
    assign take = branch_sel &&
                  ((opcode == OP_BR) || ((opcode == OP_BRZ) && zero_flag));

    assign next_pc = take ? (pc + PC_W'(sext_off(ir))) : (pc + PC_W'(1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 9-bit Program1 processor. Owns PC and IR,
// drives ALU/writeback strobes and a valid/ready data memory request.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start after reset
//   FETCH  | end-of-program check, latch instruction into IR
//   DECODE | one-cycle decode slot
//   EXEC   | ALU strobe / branch resolve / hand off to MEM
//   MEM    | dmem request held until dmem_ready
//   WB     | load writeback strobe
//   DONE   | program finished, PC holds, start restarts
module multicycle_sequencer
    import prog_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] PROG_LEN = PC_W'(1023),
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       imem_rdata,
    input  logic             zero_flag,
    input  logic             dmem_ready,
    output logic [PC_W-1:0]  pc,
    output logic [8:0]       ir,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_DONE   = ST_DONE;

    logic [2:0]      state;
    opcode_e         opcode;
    logic            is_alu;
    logic            is_mem;
    logic            start_ok;
    logic            retire;
    logic [PC_W-1:0] next_pc;

    assign opcode   = opcode_e'(ir[OPC_MSB:OPC_LSB]);
    assign is_alu   = (ir[OPC_MSB] == 1'b0);
    assign is_mem   = (opcode == OP_LDR) || (opcode == OP_STR);
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Memory ops retire when they leave MEM (store) or WB (load)
    assign retire = ((state == S_EXEC) && !is_mem) ||
                    ((state == S_MEM) && dmem_ready && (opcode == OP_STR)) ||
                    (state == S_WB);

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc         (pc),
        .ir         (ir),
        .zero_flag  (zero_flag),
        .branch_sel (state == S_EXEC),
        .next_pc    (next_pc)
    );

    // Outputs decode straight from state so reset drops them asynchronously
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign alu_op     = ((state == S_EXEC) && is_alu) ? ir[OPC_MSB:OPC_LSB] : 3'b000;
    assign reg_write  = ((state == S_EXEC) && is_alu) || (state == S_WB);
    assign mem_to_reg = (state == S_WB);
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && (opcode == OP_STR);

    // Sequencing FSM with PC and IR updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pc == PROG_LEN) begin
                        state <= S_DONE;
                    end else begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_mem) begin
                        state <= S_MEM;
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (opcode == OP_STR) begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc    <= next_pc;
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating busy-cycle and retired-instruction counters, cleared on start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (start_ok) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (busy && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (retire && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: instruction-level reference
// model with randomized programs, zero flag, memory latency and start noise.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic reset, start, zero_flag, dmem_ready, sel;
    logic [8:0] imem [0:1023];

    // Instance A: default parameters. Instance B: short program, 4-bit counters.
    logic [9:0]  pc_a, pc_b;
    logic [8:0]  ir_a, ir_b, imem_a, imem_b;
    logic [2:0]  alu_a, alu_b;
    logic        rw_a, rw_b, m2r_a, m2r_b, req_a, req_b, we_a, we_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] cyc_a, ins_a;
    logic [3:0]  cyc_b, ins_b;

    logic [9:0]  o_pc;
    logic [8:0]  o_ir;
    logic [2:0]  o_alu;
    logic        o_rw, o_m2r, o_req, o_we, o_busy, o_done;
    logic [15:0] o_cyc, o_ins;

    int total = 0, bad = 0;
    int m_pc, m_cyc, m_ins, prog_len, cnt_max;
    bit m_done;
    int mem_wait = -1;
    int zf_force = -1;
    bit fin;

    always #5 clk = ~clk;

    assign imem_a = imem[pc_a];
    assign imem_b = imem[pc_b];

    multicycle_sequencer u_dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .imem_rdata(imem_a),
        .zero_flag(zero_flag), .dmem_ready(dmem_ready), .pc(pc_a), .ir(ir_a),
        .alu_op(alu_a), .reg_write(rw_a), .mem_to_reg(m2r_a), .dmem_req(req_a),
        .dmem_we(we_a), .busy(busy_a), .done(done_a), .cycle_count(cyc_a),
        .instr_count(ins_a)
    );

    multicycle_sequencer #(.PC_W(10), .PROG_LEN(10'd4), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .imem_rdata(imem_b),
        .zero_flag(zero_flag), .dmem_ready(dmem_ready), .pc(pc_b), .ir(ir_b),
        .alu_op(alu_b), .reg_write(rw_b), .mem_to_reg(m2r_b), .dmem_req(req_b),
        .dmem_we(we_b), .busy(busy_b), .done(done_b), .cycle_count(cyc_b),
        .instr_count(ins_b)
    );

    assign o_pc   = sel ? pc_b   : pc_a;
    assign o_ir   = sel ? ir_b   : ir_a;
    assign o_alu  = sel ? alu_b  : alu_a;
    assign o_rw   = sel ? rw_b   : rw_a;
    assign o_m2r  = sel ? m2r_b  : m2r_a;
    assign o_req  = sel ? req_b  : req_a;
    assign o_we   = sel ? we_b   : we_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_cyc  = sel ? {12'd0, cyc_b} : cyc_a;
    assign o_ins  = sel ? {12'd0, ins_b} : ins_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > cnt_max) ? cnt_max : v;
    endfunction

    task automatic check_outs(input string ph, input bit b, input bit d, input logic [2:0] alu,
                              input bit chk_alu, input bit rw, input bit m2r, input bit req,
                              input bit we);
        check({ph, ".busy"}, o_busy, b);
        check({ph, ".done"}, o_done, d);
        if (chk_alu) check({ph, ".alu_op"}, o_alu, alu);
        check({ph, ".reg_write"}, o_rw, rw);
        check({ph, ".mem_to_reg"}, o_m2r, m2r);
        check({ph, ".dmem_req"}, o_req, req);
        if (req) check({ph, ".dmem_we"}, o_we, we);
        check({ph, ".pc"}, o_pc, m_pc);
        check({ph, ".cycle_count"}, o_cyc, sat(m_cyc));
        check({ph, ".instr_count"}, o_ins, sat(m_ins));
    endtask

    // Inputs that must be ignored in the current cycle get random values
    task automatic noise();
        start      = 1'($urandom_range(0, 1));
        dmem_ready = 1'($urandom_range(0, 1));
        zero_flag  = 1'($urandom_range(0, 1));
    endtask

    task automatic start_prog();
        @(negedge clk);
        check_outs("idle", 0, m_done, 3'd0, 1, 0, 0, 0, 0);
        start = 1'b1;
        dmem_ready = 1'($urandom_range(0, 1));
        m_pc = 0; m_cyc = 0; m_ins = 0; m_done = 0;
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked before any edge
    task automatic apply_reset();
        #1 reset = 1'b1;
        start = 1'b0;
        m_pc = 0; m_cyc = 0; m_ins = 0; m_done = 0;
        #1 check_outs("reset", 0, 0, 3'd0, 1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH, or the end-of-program FETCH plus DONE
    task automatic run_instr(output bit f);
        logic [8:0] ins;
        logic [2:0] op;
        int off, waits;
        bit zf, rdy;
        f = 0;
        @(negedge clk);
        check_outs("fetch", 1, 0, 3'd0, 1, 0, 0, 0, 0);
        noise();
        m_cyc++;
        if (m_pc == prog_len) begin
            f = 1;
            m_done = 1;
            @(negedge clk);
            check_outs("done", 0, 1, 3'd0, 1, 0, 0, 0, 0);
            start = 1'b0;
            return;
        end
        ins = imem[m_pc];
        op  = ins[8:6];
        off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        @(negedge clk);
        check_outs("decode", 1, 0, 3'd0, 1, 0, 0, 0, 0);
        check("decode.ir", o_ir, ins);
        noise();
        m_cyc++;
        @(negedge clk);
        check_outs("exec", 1, 0, (op < 4) ? op : 3'd0, op < 4, op < 4, 0, 0, 0);
        noise();
        if (zf_force >= 0) zero_flag = zf_force[0];
        zf = zero_flag;
        m_cyc++;
        if (op < 4) begin
            m_pc = (m_pc + 1) % 1024;
            m_ins++;
        end else if (op == 3'd6 || (op == 3'd7 && zf)) begin
            m_pc = (m_pc + off + 1024) % 1024;
            m_ins++;
        end else if (op == 3'd7) begin
            m_pc = (m_pc + 1) % 1024;
            m_ins++;
        end else begin
            waits = 0;
            do begin
                @(negedge clk);
                check_outs("mem", 1, 0, 3'd0, 1, 0, 0, 1, op == 3'd5);
                noise();
                if (mem_wait >= 0) rdy = (waits == mem_wait);
                else rdy = (waits >= 5) || ($urandom_range(0, 2) == 0);
                dmem_ready = rdy;
                waits++;
                m_cyc++;
            end while (!rdy);
            if (op == 3'd4) begin
                @(negedge clk);
                check_outs("wb", 1, 0, 3'd0, 1, 1, 1, 0, 0);
                noise();
                m_cyc++;
            end
            m_pc = (m_pc + 1) % 1024;
            m_ins++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; zero_flag = 1'b0; dmem_ready = 1'b0; sel = 1'b0;
        prog_len = 1023; cnt_max = 65535;
        m_pc = 0; m_cyc = 0; m_ins = 0; m_done = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 9'b000_000001;
        repeat (2) @(negedge clk);
        check_outs("por", 0, 0, 3'd0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        // Reset in the middle of a load handshake, then a clean restart
        imem[1] = 9'b100_000000;
        start_prog();
        run_instr(fin);
        dmem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            dmem_ready = 1'b0;
        end
        @(negedge clk);
        check("t1.req_before_reset", o_req, 1);
        check("t1.pc_before_reset", o_pc, 1);
        apply_reset();
        start_prog();
        run_instr(fin);
        run_instr(fin);
        apply_reset();

        // Single ADD, then a load with three wait states
        imem[0] = 9'b000_000001;
        imem[1] = 9'b100_000000;
        start_prog();
        run_instr(fin);
        mem_wait = 3;
        run_instr(fin);
        mem_wait = -1;
        run_instr(fin);
        apply_reset();

        // Store with random latency
        imem[1] = 9'b101_000011;
        start_prog();
        repeat (3) run_instr(fin);
        apply_reset();
        imem[1] = 9'b000_000001;

        // BRZ +5 at pc 2, taken and not taken
        imem[2] = 9'b111_000101;
        for (int z = 1; z >= 0; z--) begin
            zf_force = z;
            start_prog();
            repeat (4) run_instr(fin);
            apply_reset();
        end
        zf_force = -1;

        // BR -3 at pc 2 wraps to 1023, which is the end of the program
        imem[2] = 9'b110_111101;
        start_prog();
        repeat (3) run_instr(fin);
        run_instr(fin);
        check("t4.wrap_done", fin, 1);
        start_prog();
        run_instr(fin);
        apply_reset();
        imem[2] = 9'b000_000001;

        // Completion on the short-program instance
        sel = 1'b1;
        prog_len = 4;
        cnt_max = 15;
        apply_reset();
        start_prog();
        fin = 0;
        for (int k = 0; k < 8 && !fin; k++) run_instr(fin);
        check("t5.finished", fin, 1);
        check("t5.cycle_count", o_cyc, 13);
        check("t5.instr_count", o_ins, 4);
        start_prog();
        run_instr(fin);
        apply_reset();

        // Saturation: endless loop ADD,ADD,ADD,BR -3
        imem[3] = 9'b110_111101;
        start_prog();
        repeat (25) run_instr(fin);
        check("t6.cycle_sat", o_cyc, 15);
        check("t6.instr_sat", o_ins, 15);
        apply_reset();
        imem[3] = 9'b000_000001;

        // Random programs on the default instance
        sel = 1'b0;
        prog_len = 1023;
        cnt_max = 65535;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 1024; i++) imem[i] = 9'($urandom);
            start_prog();
            fin = 0;
            for (int k = 0; k < 300 && !fin; k++) run_instr(fin);
            apply_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
